// File: rtl/alsu_drv_pkg.sv
// Shared definitions for the ALSU command driver: command field layout, pin bundle,
// idle vector, FSM states and ALSU opcode names.
package alsu_drv_pkg;

    localparam int unsigned A_LSB   = 0;
    localparam int unsigned B_LSB   = 3;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned CIN     = 9;
    localparam int unsigned SER     = 10;
    localparam int unsigned RA      = 11;
    localparam int unsigned RB      = 12;
    localparam int unsigned BA      = 13;
    localparam int unsigned BB      = 14;
    localparam int unsigned DIR     = 15;
    localparam int unsigned REP_LSB = 16;
    localparam int unsigned PIN_W   = 16;

    typedef struct packed {
        logic       direction;
        logic       bypass_b;
        logic       bypass_a;
        logic       red_op_b;
        logic       red_op_a;
        logic       serial_in;
        logic       cin;
        logic [2:0] opcode;
        logic [2:0] b;
        logic [2:0] a;
    } alsu_pins_t;

    localparam alsu_pins_t IDLE_PINS = '0;

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} drv_state_t;

    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    function automatic alsu_pins_t unpack_cmd(input logic [PIN_W-1:0] c);
        alsu_pins_t p;
        p.a         = c[A_LSB +: 3];
        p.b         = c[B_LSB +: 3];
        p.opcode    = c[OP_LSB +: 3];
        p.cin       = c[CIN];
        p.serial_in = c[SER];
        p.red_op_a  = c[RA];
        p.red_op_b  = c[RB];
        p.bypass_a  = c[BA];
        p.bypass_b  = c[BB];
        p.direction = c[DIR];
        return p;
    endfunction

endpackage

// File: rtl/alsu_drv_fifo.sv
// Synchronous command FIFO with asynchronous active-high reset. DEPTH must be a power of 2.
module alsu_drv_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/alsu_cmd_driver.sv
// Initiator-side ALSU command driver: FIFO-buffered commands, timed pin drive, one response each.
// Optional stat_cmds/stat_invalid counters are built when ALSU_DRV_STATS_EN is defined.
module alsu_cmd_driver
    import alsu_drv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned REPEAT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [PIN_W+REPEAT_W-1:0] cmd_data,
    output logic [2:0]                alsu_A,
    output logic [2:0]                alsu_B,
    output logic [2:0]                alsu_opcode,
    output logic                      alsu_cin,
    output logic                      alsu_serial_in,
    output logic                      alsu_red_op_A,
    output logic                      alsu_red_op_B,
    output logic                      alsu_bypass_A,
    output logic                      alsu_bypass_B,
    output logic                      alsu_direction,
    input  logic [5:0]                alsu_out,
    input  logic [15:0]               alsu_leds,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [5:0]                rsp_out,
    output logic [15:0]               rsp_leds,
    output logic                      rsp_invalid
`ifdef ALSU_DRV_STATS_EN
    ,
    output logic [15:0]               stat_cmds,
    output logic [15:0]               stat_invalid
`endif
);

    localparam int unsigned CW    = PIN_W + REPEAT_W;
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    drv_state_t        state_q, state_d;
    alsu_pins_t        pins_q, pins_d;
    logic [REPEAT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [5:0]        rsp_out_q, rsp_out_d;
    logic [15:0]       rsp_leds_q, rsp_leds_d;
    logic              rsp_invalid_q, rsp_invalid_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_rdata;

    assign cmd_ready = !fifo_full;

    alsu_drv_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pins_q        <= IDLE_PINS;
            rep_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_out_q     <= '0;
            rsp_leds_q    <= '0;
            rsp_invalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pins_q        <= pins_d;
            rep_cnt_q     <= rep_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_out_q     <= rsp_out_d;
            rsp_leds_q    <= rsp_leds_d;
            rsp_invalid_q <= rsp_invalid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pins_d        = pins_q;
        rep_cnt_d     = rep_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_out_d     = rsp_out_q;
        rsp_leds_d    = rsp_leds_q;
        rsp_invalid_d = rsp_invalid_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                pins_d = IDLE_PINS;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    pins_d    = unpack_cmd(fifo_rdata[PIN_W-1:0]);
                    rep_cnt_d = fifo_rdata[REP_LSB +: REPEAT_W];
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                // Counting down to zero keeps all-ones repeat at 2^REPEAT_W cycles without wrap.
                if (rep_cnt_q == '0) begin
                    pins_d    = IDLE_PINS;
                    lat_cnt_d = LAT_W'(LATENCY - 1);
                    state_d   = WAIT;
                end else begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_out_d     = alsu_out;
                    rsp_leds_d    = alsu_leds;
                    rsp_invalid_d = (alsu_leds != '0);
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alsu_A         = pins_q.a;
    assign alsu_B         = pins_q.b;
    assign alsu_opcode    = pins_q.opcode;
    assign alsu_cin       = pins_q.cin;
    assign alsu_serial_in = pins_q.serial_in;
    assign alsu_red_op_A  = pins_q.red_op_a;
    assign alsu_red_op_B  = pins_q.red_op_b;
    assign alsu_bypass_A  = pins_q.bypass_a;
    assign alsu_bypass_B  = pins_q.bypass_b;
    assign alsu_direction = pins_q.direction;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_out     = rsp_out_q;
    assign rsp_leds    = rsp_leds_q;
    assign rsp_invalid = rsp_invalid_q;

`ifdef ALSU_DRV_STATS_EN
    logic        rsp_hs;
    logic [15:0] stat_cmds_q;
    logic [15:0] stat_invalid_q;

    assign rsp_hs = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cmds_q    <= '0;
            stat_invalid_q <= '0;
        end else if (rsp_hs) begin
            if (stat_cmds_q != '1) stat_cmds_q <= stat_cmds_q + 1'b1;
            if (rsp_invalid_q && (stat_invalid_q != '1)) stat_invalid_q <= stat_invalid_q + 1'b1;
        end
    end

    assign stat_cmds    = stat_cmds_q;
    assign stat_invalid = stat_invalid_q;
`endif

endmodule
